// File: rtl/wb_slot_sched_pkg.sv
// Shared widths, command codes and the writeback slot record used by the
// writeback slot scheduler.
package scb_pkg;

  localparam int I_BL_EX_PIP   = 3;
  localparam int I_BL_MARC_REG = 6;

  localparam logic [3:0] CMD_ROB_FILL = 4'h1;

  typedef struct packed {
    logic                     valid;
    logic [I_BL_EX_PIP-1:0]   pip;
    logic [I_BL_MARC_REG-1:0] preg;
  } wb_slot_t;

  localparam wb_slot_t WB_SLOT_EMPTY = '{valid: 1'b0, pip: '0, preg: '0};

  function automatic wb_slot_t wb_slot_fill(input logic [I_BL_EX_PIP-1:0]   pip,
                                            input logic [I_BL_MARC_REG-1:0] preg);
    wb_slot_t s;
    s.valid = 1'b1;
    s.pip   = pip;
    s.preg  = preg;
    return s;
  endfunction

endpackage

// File: rtl/wb_slot_sched_if.sv
// Requester/ROB-fill bundle of the writeback slot scheduler; the scheduler
// takes the slave view, the issue logic (or bench) the master view.
interface wb_slot_sched_if #(
  parameter int N_REQ   = 4,
  parameter int MAX_LAT = 8
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic [N_REQ-1:0]                        req_valid;
  logic [N_REQ*scb_pkg::I_BL_EX_PIP-1:0]   req_pip;
  logic [N_REQ*LAT_W-1:0]                  req_lat;
  logic [N_REQ*scb_pkg::I_BL_MARC_REG-1:0] req_preg;
  logic [N_REQ-1:0]                        grant;
  logic [scb_pkg::I_BL_EX_PIP-1:0]         fill_pip;
  logic [scb_pkg::I_BL_MARC_REG-1:0]       fill_preg;
  logic [MAX_LAT-1:0]                      slot_occ;

  modport master (
    output req_valid, req_pip, req_lat, req_preg,
    input  grant, fill_pip, fill_preg, slot_occ
  );

  modport slave (
    input  req_valid, req_pip, req_lat, req_preg,
    output grant, fill_pip, fill_preg, slot_occ
  );

endinterface

// File: rtl/wb_slot_sched_rr_picker.sv
// Round-robin one-hot picker: first asserted request at or after the pointer,
// wrapping modulo N.
module rr_picker import scb_pkg::*; #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic w_found;
  int   w_idx;

  // scan from the pointer, first hit wins
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/wb_slot_sched.sv
// Writeback slot scheduler: reserves the fill-stage cycle of fixed-latency
// pipes so at most one instruction enters the ROB per cycle.
module wb_slot_sched import scb_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int MAX_LAT = 8
) (
  input  logic            clk,
  input  logic            clear,
  wb_slot_sched_if.slave  bus
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  wb_slot_t                 r_slot     [MAX_LAT];
  wb_slot_t                 w_slot_nxt [MAX_LAT];
  logic [PTR_W-1:0]         r_rr_ptr;
  logic [PTR_W-1:0]         w_rr_ptr_nxt;
  logic [MAX_LAT:0]         w_busy;
  logic [N_REQ-1:0]         w_elig;
  logic [N_REQ-1:0]         w_pick;
  logic [N_REQ-1:0]         w_grant;
  logic [LAT_W-1:0]         w_lat;
  logic                     w_gnt_any;
  logic [LAT_W-1:0]         w_gnt_lat;
  logic [I_BL_EX_PIP-1:0]   w_gnt_pip;
  logic [I_BL_MARC_REG-1:0] w_gnt_preg;

  // Bit MAX_LAT stands for the slot one past the array: it never holds anything.
  always_comb begin
    w_busy = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      w_busy[k] = r_slot[k].valid;
    end
  end

  always_comb begin
    w_elig = '0;
    w_lat  = '0;
    for (int r = 0; r < N_REQ; r++) begin
      w_lat = bus.req_lat[r*LAT_W +: LAT_W];
      if (bus.req_valid[r] && (w_lat != '0) && (int'(w_lat) <= MAX_LAT)) begin
        w_elig[r] = !w_busy[w_lat];
      end else begin
        w_elig[r] = 1'b0;
      end
    end
  end

  rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_rr_picker (
    .i_req (w_elig),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  assign w_grant   = clear ? '0 : w_pick;
  assign bus.grant = w_grant;

  always_comb begin
    w_gnt_any    = |w_grant;
    w_gnt_lat    = '0;
    w_gnt_pip    = '0;
    w_gnt_preg   = '0;
    w_rr_ptr_nxt = r_rr_ptr;
    for (int r = 0; r < N_REQ; r++) begin
      if (w_grant[r]) begin
        w_gnt_lat    = bus.req_lat[r*LAT_W +: LAT_W];
        w_gnt_pip    = bus.req_pip[r*I_BL_EX_PIP +: I_BL_EX_PIP];
        w_gnt_preg   = bus.req_preg[r*I_BL_MARC_REG +: I_BL_MARC_REG];
        w_rr_ptr_nxt = (r == N_REQ - 1) ? '0 : PTR_W'(r + 1);
      end else begin
        w_rr_ptr_nxt = w_rr_ptr_nxt;
      end
    end
  end

  // Shift toward the fill stage, then drop the new reservation at L-1.
  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      w_slot_nxt[k] = r_slot[k+1];
    end
    w_slot_nxt[MAX_LAT-1] = WB_SLOT_EMPTY;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (w_gnt_any && (int'(w_gnt_lat) == k + 1)) begin
        w_slot_nxt[k] = wb_slot_fill(w_gnt_pip, w_gnt_preg);
      end else begin
        w_slot_nxt[k] = w_slot_nxt[k];
      end
    end
  end

  // slot pipeline and round-robin pointer
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < MAX_LAT; k++) begin
        r_slot[k] <= WB_SLOT_EMPTY;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++) begin
        r_slot[k] <= w_slot_nxt[k];
      end
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign bus.fill_pip  = r_slot[0].valid ? r_slot[0].pip : '0;
  assign bus.fill_preg = r_slot[0].preg;

  always_comb begin
    bus.slot_occ = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      bus.slot_occ[k] = r_slot[k].valid;
    end
  end

endmodule

// File: tb/tb_wb_slot_sched.sv
// Directed and randomized bench for wb_slot_sched against a fill-calendar
// model: each grant books the absolute cycle at which its fill must appear.
module tb_wb_slot_sched;
  import scb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int MAX_LAT = 8;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  logic clk   = 1'b0;
  logic clear = 1'b1;

  always #5 clk = ~clk;

  wb_slot_sched_if #(.N_REQ(N_REQ), .MAX_LAT(MAX_LAT)) bus ();

  wb_slot_sched #(.N_REQ(N_REQ), .MAX_LAT(MAX_LAT)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  logic                     v    [N_REQ];
  logic [LAT_W-1:0]         lat  [N_REQ];
  logic [I_BL_EX_PIP-1:0]   pip  [N_REQ];
  logic [I_BL_MARC_REG-1:0] preg [N_REQ];

  logic [8:0]       sched [int];
  int               mptr  = 0;
  int               cyc   = 0;
  bit               known = 1'b0;
  logic [N_REQ-1:0] exp_gnt;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int r = 0; r < N_REQ; r++) begin
      bus.req_valid[r]                          = v[r];
      bus.req_lat[r*LAT_W +: LAT_W]             = lat[r];
      bus.req_pip[r*I_BL_EX_PIP +: I_BL_EX_PIP] = pip[r];
      bus.req_preg[r*I_BL_MARC_REG +: I_BL_MARC_REG] = preg[r];
    end
  endtask

  task automatic req(input int r, input bit val, input int l, input int p, input int g);
    v[r]    = val;
    lat[r]  = LAT_W'(l);
    pip[r]  = I_BL_EX_PIP'(p);
    preg[r] = I_BL_MARC_REG'(g);
    apply();
  endtask

  task automatic sample();
    logic [MAX_LAT-1:0] occ;
    int r;
    @(negedge clk);
    exp_gnt = '0;
    if (!clear) begin
      for (int off = 0; off < N_REQ; off++) begin
        r = (mptr + off) % N_REQ;
        if (exp_gnt == '0 && v[r] && lat[r] >= 1 && lat[r] <= MAX_LAT
            && !sched.exists(cyc + int'(lat[r])))
          exp_gnt[r] = 1'b1;
      end
    end
    chk("grant", bus.grant, exp_gnt);
    if (known) begin
      chk("fill_pip", bus.fill_pip, sched.exists(cyc) ? sched[cyc][8:6] : 3'd0);
      if (sched.exists(cyc)) chk("fill_preg", bus.fill_preg, sched[cyc][5:0]);
      for (int k = 0; k < MAX_LAT; k++) occ[k] = sched.exists(cyc + k);
      chk("slot_occ", bus.slot_occ, occ);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (clear) begin
      sched.delete();
      mptr  = 0;
      known = 1'b1;
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (exp_gnt[r]) begin
          sched[cyc + int'(lat[r])] = {pip[r], preg[r]};
          mptr = (r + 1) % N_REQ;
        end
      end
    end
    if (sched.exists(cyc)) sched.delete(cyc);
    cyc++;
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle_all();
    for (int r = 0; r < N_REQ; r++) req(r, 1'b0, 0, 0, 0);
  endtask

  task automatic do_clear();
    idle_all();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int l;
    idle_all();

    // reset state
    do_clear();
    sample();
    chk("rst_fill", bus.fill_pip, 3'd0);
    chk("rst_occ", bus.slot_occ, 8'h00);
    advance();

    // single lat-3 request
    do_clear();
    req(1, 1'b1, 3, 2, 17);
    sample(); chk("r028_gnt", bus.grant, 4'b0010); advance();
    req(1, 1'b0, 0, 0, 0);
    tick(); tick();
    sample(); chk("r028_pip", bus.fill_pip, 3'd2); chk("r028_preg", bus.fill_preg, 6'd17); advance();
    sample(); chk("r028_once", bus.fill_pip, 3'd0); advance();

    // slot conflict delays a shorter-latency request
    do_clear();
    req(0, 1'b1, 4, 1, 5);
    sample(); chk("r029_g0", bus.grant, 4'b0001); advance();
    req(0, 1'b0, 0, 0, 0); req(1, 1'b1, 3, 3, 9);
    sample(); chk("r029_g1", bus.grant, 4'b0000); advance();
    sample(); chk("r029_g2", bus.grant, 4'b0010); advance();
    req(1, 1'b0, 0, 0, 0);
    tick();
    sample(); chk("r029_f4", bus.fill_pip, 3'd1); advance();
    sample(); chk("r029_f5", bus.fill_pip, 3'd3); advance();

    // all requesters at MAX_LAT: rotation and fill order
    do_clear();
    for (int r = 0; r < N_REQ; r++) req(r, 1'b1, MAX_LAT, r + 1, r + 10);
    for (int c = 0; c <= 12; c++) begin
      sample();
      if (c < 5) chk("r030_gnt", bus.grant, 32'(1) << (c % 4));
      if (c >= 8) chk("r030_fill", bus.fill_pip, 32'((c - 8) % 4 + 1));
      advance();
    end

    // round-robin tie at equal latency
    do_clear();
    req(0, 1'b1, 2, 5, 3); req(2, 1'b1, 2, 6, 4);
    sample(); chk("r031_g0", bus.grant, 4'b0001); advance();
    req(0, 1'b0, 0, 0, 0);
    sample(); chk("r031_g1", bus.grant, 4'b0100); advance();
    req(2, 1'b0, 0, 0, 0);
    sample(); chk("r031_f2", bus.fill_pip, 3'd5); advance();
    sample(); chk("r031_f3", bus.fill_pip, 3'd6); advance();

    // clear drops pending fill and pointer
    do_clear();
    req(0, 1'b1, 6, 7, 1);
    sample(); chk("r032_g0", bus.grant, 4'b0001); advance();
    req(0, 1'b0, 0, 0, 0);
    tick();
    clear = 1'b1; req(1, 1'b1, 2, 2, 2);
    sample(); chk("r032_gclr", bus.grant, 4'b0000); advance();
    clear = 1'b0; req(1, 1'b0, 0, 0, 0);
    sample(); chk("r032_occ", bus.slot_occ, 8'h00); advance();
    tick(); tick();
    sample(); chk("r032_nofill", bus.fill_pip, 3'd0); advance();
    req(0, 1'b1, 1, 1, 1); req(1, 1'b1, 1, 2, 2);
    sample(); chk("r032_ptr", bus.grant, 4'b0001); advance();
    idle_all();
    tick(); tick();

    // illegal latencies never granted
    do_clear();
    req(3, 1'b1, 0, 1, 1); req(2, 1'b1, 9, 2, 2); req(1, 1'b1, 5, 3, 3);
    sample(); chk("r033_g0", bus.grant, 4'b0010); advance();
    req(1, 1'b0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      sample(); chk("r033_none", bus.grant, 4'b0000); advance();
    end

    // randomized traffic with occasional clears
    do_clear();
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (!v[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            l = int'($urandom_range(0, 9));
            req(r, 1'b1, l, int'($urandom_range(1, 7)), int'($urandom_range(0, 63)));
          end
        end else if ((lat[r] == 0 || lat[r] > MAX_LAT) && $urandom_range(0, 3) == 0) begin
          req(r, 1'b0, 0, 0, 0);
        end
      end
      clear = ($urandom_range(0, 63) == 0);
      tick();
      for (int r = 0; r < N_REQ; r++) begin
        if (exp_gnt[r]) req(r, 1'b0, 0, 0, 0);
      end
    end
    clear = 1'b0;
    idle_all();
    for (int c = 0; c < MAX_LAT + 1; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
